prio_heap_queue: RTL and testbench
==================================

# prio_heap_queue

Parametrised successor to the sorted-array quick queue: a binary-heap priority queue that holds up to DEPTH key/payload entries and always presents the best entry (min or max key, by parameter) at its head. Insertion and removal take one heap level per cycle instead of one array slot per cycle. A run-time capacity limit replaces the fixed array size. Valid/ready handshakes on both the enqueue and dequeue sides replace the level-sensitive enq/deq strobes. It sits between the scheduler front end and the consumer that drains entries in priority order.

## Interface
- KEY_W, default 32: priority key width.
- DATA_W, default 32: payload width carried with each key.
- DEPTH, default 7: storage entries; must be 2^k-1, k≥2.
- MAX_FIRST, default 0: 0 = smallest key at head; 1 = largest key at head.
- CW = $clog2(DEPTH+1): derived count width.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset; clears all state immediately.
- enq_valid  in  1  producer offers an entry.
- enq_ready  out  1  entry accepted on a clk edge where enq_valid && enq_ready.
- enq_key  in  KEY_W  key of offered entry.
- enq_data  in  DATA_W  payload of offered entry.
- deq_valid  out  1  head entry is available.
- deq_ready  in  1  consumer takes the head on a clk edge where deq_valid && deq_ready.
- deq_key  out  KEY_W  key at heap root, heap[0].
- deq_data  out  DATA_W  payload at heap root.
- limit  in  CW  run-time capacity; 0 or >DEPTH means DEPTH.
- count  out  CW  stored entries.
- empty  out  1  count==0.
- full  out  1  count ≥ effective limit.
- busy  out  1  sift in progress.

## Operation
- States: IDLE, SIFT_UP, SIFT_DOWN. Handshakes only complete in IDLE.
- better(a,b) is strict. MAX_FIRST=0: a.key<b.key. MAX_FIRST=1: a.key>b.key. Unsigned compare.
- deq_valid = IDLE && count>0.
- enq_ready = IDLE && (count<eff_limit || (deq_valid && deq_ready)).
- Enqueue only:
  - Write entry to heap[count]; count+1.
  - Go to SIFT_UP with idx=old count.
- Dequeue only:
  - Copy heap[count-1] to heap[0]; count-1.
  - If the new count is 0, stay IDLE; otherwise go to SIFT_DOWN with idx=0.
- Both fire (replace-top):
  - Write the new entry to heap[0]; count unchanged.
  - Go to SIFT_DOWN with idx=0.
  - Allowed when full.
  - When empty only the enqueue fires, since deq_valid=0.
- SIFT_UP, one compare per cycle:
  - p=(idx-1)/2.
  - If idx==0 or !better(heap[idx],heap[p]): go to IDLE.
  - Else swap the two entries and set idx=p.
- SIFT_DOWN, one compare per cycle:
  - Children 2idx+1 and 2idx+2; only children with index <count are valid.
  - Pick the better child; the left child wins on equal keys.
  - If no valid child, or !better(child,heap[idx]): go to IDLE.
  - Else swap and set idx=child.
- Equal keys are never swapped. Ordering among equal keys follows the algorithm and is not FIFO.
- Lowering limit below count evicts nothing. Only full=1 and enq_ready=0 until count drops below the limit.
- Key and payload move together on every swap.

## Timing
- Reset, asynchronous and active-low: all storage cleared to 0, count=0, state=IDLE.
- Output values during and after reset:
  - deq_valid=0, deq_key=0, deq_data=0.
  - empty=1, full=0, busy=0.
  - enq_ready=1 as soon as rst deasserts (limit≥1).
- Reset mid-sift abandons the operation; all contents are lost.
- Accept edge T: count, empty and full update at T.
- busy=1 from T+1 for s+1 cycles, where s = number of swaps. IDLE resumes at T+s+2.
- Worst case busy is k cycles for DEPTH=2^k-1: 3 cycles at DEPTH=7, 4 cycles at DEPTH=15.
- Dequeue leaving count 0: no busy cycles; enq_ready=1 at T+1.
- deq_key and deq_data are registered heap[0]. They are valid whenever deq_valid=1; their value during busy is don't-care.
- enq_ready and deq_valid are combinational from state, count, limit and deq_ready.
- No combinational path from enq_valid to any output.

## Test plan
- Empty dequeue: after reset, DEPTH=7, hold deq_ready=1 for 2 cycles.
  - deq_valid=0, count=0, empty=1, busy=0 throughout.
- Min-heap fill: MAX_FIRST=0, limit=3; enqueue keys 4, 2, 9, waiting for busy=0 after each.
  - Head after each enqueue is 4, 2, 2.
  - count=3, full=1.
  - busy lasts 1 cycle for key 4, 2 cycles for key 2 (one swap), 1 cycle for key 9.
- Full blocking: from the previous state, enq_valid=1 with key 7 and deq_ready=0 for 10 cycles.
  - enq_ready=0, count=3, head=2.
- Replace-top: from the same full state, key 3 with enq_valid=1 and deq_ready=1 for one cycle.
  - Pops key 2; count stays 3; head becomes 3.
  - Drain then yields 3, 4, 9, then empty=1.
- Max mode: MAX_FIRST=1, DEPTH=7; enqueue 5, 1, 8, 3 with payloads 0xA..0xD.
  - Drain yields key/payload pairs (8,0xC), (5,0xA), (3,0xD), (1,0xB).
- Async reset mid-sift: assert rst low between clk edges while busy=1 in SIFT_DOWN.
  - count=0, deq_valid=0, busy=0 before the next edge.
  - The first enqueue after release of key 6 gives head 6.

Source files
------------

// File: rtl/prio_heap_queue.sv
// Binary-heap priority queue: DEPTH key/payload entries with the best key at the root.
// Inserts sift up and removals sift down, one heap level per clock.
module prio_heap_queue #(
    parameter int KEY_W     = 32,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 7,
    parameter int MAX_FIRST = 0,
    parameter int CW        = $clog2(DEPTH+1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              enq_valid_i,
    output logic              enq_ready_o,
    input  logic [KEY_W-1:0]  enq_key_i,
    input  logic [DATA_W-1:0] enq_data_i,
    output logic              deq_valid_o,
    input  logic              deq_ready_i,
    output logic [KEY_W-1:0]  deq_key_o,
    output logic [DATA_W-1:0] deq_data_o,
    input  logic [CW-1:0]     limit_i,
    output logic [CW-1:0]     count_o,
    output logic              empty_o,
    output logic              full_o,
    output logic              busy_o
);

    typedef struct packed {
        logic [KEY_W-1:0]  key;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, SIFT_UP, SIFT_DOWN} state_t;

    state_t        state_q, state_d;
    entry_t        heap_q [DEPTH];
    entry_t        heap_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] idx_q, idx_d;
    logic [CW-1:0] eff_limit;
    logic [CW-1:0] parent, last, child;
    logic [CW:0]   lc, rc;
    logic          lc_ok, rc_ok;
    logic          enq_fire, deq_fire;
    entry_t        new_e;

    // Strict compare: equal keys never count as better, so they are never swapped.
    function automatic logic better(input logic [KEY_W-1:0] a, input logic [KEY_W-1:0] b);
        if (MAX_FIRST != 0) return a > b;
        return a < b;
    endfunction

    assign eff_limit = (limit_i == '0 || int'(limit_i) > DEPTH) ? CW'(DEPTH) : limit_i;

    assign deq_valid_o = (state_q == IDLE) && (count_q != '0);
    assign enq_ready_o = (state_q == IDLE) &&
                         ((count_q < eff_limit) || (deq_valid_o && deq_ready_i));
    assign enq_fire    = enq_valid_i && enq_ready_o;
    assign deq_fire    = deq_valid_o && deq_ready_i;
    assign new_e       = '{key: enq_key_i, data: enq_data_i};

    assign parent = (idx_q - CW'(1)) >> 1;
    assign last   = count_q - CW'(1);
    assign lc     = {idx_q, 1'b1};
    assign rc     = lc + (CW+1)'(1);
    assign lc_ok  = lc < {1'b0, count_q};
    assign rc_ok  = rc < {1'b0, count_q};
    // Left child wins ties; the right one is only chosen when strictly better.
    assign child  = (rc_ok && better(heap_q[rc[CW-1:0]].key, heap_q[lc[CW-1:0]].key))
                    ? rc[CW-1:0] : lc[CW-1:0];

    always_comb begin
        heap_d  = heap_q;
        count_d = count_q;
        idx_d   = idx_q;
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enq_fire && deq_fire) begin
                    heap_d[0] = new_e;
                    idx_d     = '0;
                    state_d   = SIFT_DOWN;
                end else if (enq_fire) begin
                    heap_d[count_q] = new_e;
                    count_d         = count_q + CW'(1);
                    idx_d           = count_q;
                    state_d         = SIFT_UP;
                end else if (deq_fire) begin
                    heap_d[0] = heap_q[last];
                    count_d   = last;
                    idx_d     = '0;
                    if (last != '0) state_d = SIFT_DOWN;
                end
            end
            SIFT_UP: begin
                if (idx_q == '0 || !better(heap_q[idx_q].key, heap_q[parent].key)) begin
                    state_d = IDLE;
                end else begin
                    heap_d[idx_q]  = heap_q[parent];
                    heap_d[parent] = heap_q[idx_q];
                    idx_d          = parent;
                end
            end
            SIFT_DOWN: begin
                if (!lc_ok || !better(heap_q[child].key, heap_q[idx_q].key)) begin
                    state_d = IDLE;
                end else begin
                    heap_d[idx_q] = heap_q[child];
                    heap_d[child] = heap_q[idx_q];
                    idx_d         = child;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            for (int i = 0; i < DEPTH; i++) heap_q[i] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            heap_q  <= heap_d;
        end
    end

    assign deq_key_o  = heap_q[0].key;
    assign deq_data_o = heap_q[0].data;
    assign count_o    = count_q;
    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q >= eff_limit);
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_prio_heap_queue.sv
// Bench for prio_heap_queue: directed tables for min/max heaps, corner sequences,
// and random traffic checked against a multiset model of the stored entries.
module tb_prio_heap_queue;

    logic       clk = 0;
    logic       rst_n = 0;
    logic       sel = 0;
    logic       enq_valid = 0, deq_ready = 0;
    logic [7:0] enq_key = 0, enq_data = 0;
    logic [2:0] limit = 0;

    logic       er0, dv0, em0, fu0, bz0, er1, dv1, em1, fu1, bz1;
    logic [7:0] dk0, dd0, dk1, dd1;
    logic [2:0] c0, c1;

    wire        enq_ready = sel ? er1 : er0;
    wire        deq_valid = sel ? dv1 : dv0;
    wire        empty     = sel ? em1 : em0;
    wire        full      = sel ? fu1 : fu0;
    wire        busy      = sel ? bz1 : bz0;
    wire [7:0]  deq_key   = sel ? dk1 : dk0;
    wire [7:0]  deq_data  = sel ? dd1 : dd0;
    wire [2:0]  count     = sel ? c1 : c0;

    always #5 clk = ~clk;

    prio_heap_queue #(.KEY_W(8), .DATA_W(8), .DEPTH(7), .MAX_FIRST(0)) u_min (
        .clk_i(clk), .rst_ni(rst_n),
        .enq_valid_i(enq_valid && !sel), .enq_ready_o(er0),
        .enq_key_i(enq_key), .enq_data_i(enq_data),
        .deq_valid_o(dv0), .deq_ready_i(deq_ready && !sel),
        .deq_key_o(dk0), .deq_data_o(dd0),
        .limit_i(limit), .count_o(c0), .empty_o(em0), .full_o(fu0), .busy_o(bz0));

    prio_heap_queue #(.KEY_W(8), .DATA_W(8), .DEPTH(7), .MAX_FIRST(1)) u_max (
        .clk_i(clk), .rst_ni(rst_n),
        .enq_valid_i(enq_valid && sel), .enq_ready_o(er1),
        .enq_key_i(enq_key), .enq_data_i(enq_data),
        .deq_valid_o(dv1), .deq_ready_i(deq_ready && sel),
        .deq_key_o(dk1), .deq_data_o(dd1),
        .limit_i(limit), .count_o(c1), .empty_o(em1), .full_o(fu1), .busy_o(bz1));

    int n_chk = 0;
    int n_fail = 0;

    typedef struct { logic [7:0] k; logic [7:0] d; } ent_t;
    ent_t mq[$];

    typedef struct { logic [7:0] key; logic [7:0] head; int bsy; int cnt; logic full; } fill_vec_t;
    typedef struct { logic [7:0] in_k; logic [7:0] in_d; logic [7:0] ex_k; logic [7:0] ex_d; } max_vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int best_idx(input bit maxf);
        int bi = 0;
        for (int i = 1; i < mq.size(); i++)
            if (maxf ? (mq[i].k > mq[bi].k) : (mq[i].k < mq[bi].k)) bi = i;
        return bi;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; enq_valid = 0; deq_ready = 0; limit = 0;
        #2;
        check("rst_deq_valid", deq_valid, 0);
        check("rst_deq_key", deq_key, 0);
        check("rst_deq_data", deq_data, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("rst_enq_ready", enq_ready, 1);
        mq.delete();
    endtask

    task automatic wait_idle(output int b);
        b = 0;
        @(negedge clk);
        while (busy && b < 50) begin
            b++;
            @(negedge clk);
        end
    endtask

    task automatic do_enq(input logic [7:0] k, input logic [7:0] d, output int b);
        int t = 0;
        @(negedge clk);
        enq_valid = 1; enq_key = k; enq_data = d; deq_ready = 0;
        #1;
        while (!enq_ready && t < 50) begin
            @(negedge clk); #1; t++;
        end
        check("enq_wait", enq_ready, 1);
        @(posedge clk); #1;
        enq_valid = 0;
        wait_idle(b);
    endtask

    task automatic do_deq(output logic [7:0] k, output logic [7:0] d, output int b);
        int t = 0;
        @(negedge clk);
        deq_ready = 1; enq_valid = 0;
        #1;
        while (!deq_valid && t < 50) begin
            @(negedge clk); #1; t++;
        end
        check("deq_wait", deq_valid, 1);
        k = deq_key; d = deq_data;
        @(posedge clk); #1;
        deq_ready = 0;
        wait_idle(b);
    endtask

    task automatic run_random(input int ncyc);
        int   bl = 0;
        int   eff, bi, fi;
        bit   exp_dv, exp_er, df, ef;
        logic [7:0] dk, dd;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            enq_valid = ($urandom_range(0, 99) < 60);
            enq_key   = 8'($urandom_range(0, 15));
            enq_data  = 8'($urandom);
            deq_ready = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 19) == 0) limit = 3'($urandom_range(0, 7));
            #1;
            eff    = (limit == 0) ? 7 : int'(limit);
            exp_dv = !busy && mq.size() > 0;
            exp_er = !busy && (mq.size() < eff || (exp_dv && deq_ready));
            bl     = busy ? bl + 1 : 0;
            check("rnd_busy_len", bl > 3, 0);
            check("rnd_count", count, mq.size());
            check("rnd_empty", empty, mq.size() == 0);
            check("rnd_full", full, mq.size() >= eff);
            check("rnd_deq_valid", deq_valid, exp_dv);
            check("rnd_enq_ready", enq_ready, exp_er);
            if (exp_dv) begin
                bi = best_idx(sel);
                check("rnd_head_key", deq_key, mq[bi].k);
            end
            dk = deq_key; dd = deq_data;
            df = exp_dv && deq_ready;
            ef = exp_er && enq_valid;
            @(posedge clk);
            if (df) begin
                fi = -1;
                for (int i = 0; i < mq.size(); i++)
                    if (fi < 0 && mq[i].k == dk && mq[i].d == dd) fi = i;
                check("rnd_pop_pair_found", fi >= 0, 1);
                mq.delete(fi >= 0 ? fi : best_idx(sel));
            end
            if (ef) mq.push_back('{enq_key, enq_data});
        end
        @(negedge clk);
        enq_valid = 0; deq_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_vec_t  fv[3];
        max_vec_t   mv[4];
        logic [7:0] drain_min[3];
        logic [7:0] k, d;
        int         b;

        fv[0] = '{8'd4, 8'd4, 1, 1, 1'b0};
        fv[1] = '{8'd2, 8'd2, 2, 2, 1'b0};
        fv[2] = '{8'd9, 8'd2, 1, 3, 1'b1};
        mv[0] = '{8'd5, 8'hA, 8'd8, 8'hC};
        mv[1] = '{8'd1, 8'hB, 8'd5, 8'hA};
        mv[2] = '{8'd8, 8'hC, 8'd3, 8'hD};
        mv[3] = '{8'd3, 8'hD, 8'd1, 8'hB};
        drain_min[0] = 8'd3; drain_min[1] = 8'd4; drain_min[2] = 8'd9;

        sel = 0;
        do_reset();

        // Dequeue request against an empty queue does nothing.
        deq_ready = 1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check("empty_deq_valid", deq_valid, 0);
            check("empty_deq_count", count, 0);
            check("empty_deq_empty", empty, 1);
            check("empty_deq_busy", busy, 0);
        end
        deq_ready = 0;

        limit = 3;
        for (int i = 0; i < 3; i++) begin
            do_enq(fv[i].key, 8'(8'h10 + i), b);
            check("fill_busy_cycles", b, fv[i].bsy);
            check("fill_head", deq_key, fv[i].head);
            check("fill_count", count, fv[i].cnt);
            check("fill_full", full, fv[i].full);
        end

        // Full and no dequeue: offer must be held off.
        enq_valid = 1; enq_key = 7; enq_data = 8'h77; deq_ready = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check("block_enq_ready", enq_ready, 0);
        end
        check("block_count", count, 3);
        check("block_head", deq_key, 2);
        enq_valid = 0;

        // Replace-top while full.
        @(negedge clk);
        enq_valid = 1; enq_key = 3; enq_data = 8'h33; deq_ready = 1;
        #1;
        check("rt_enq_ready", enq_ready, 1);
        check("rt_popped_key", deq_key, 2);
        @(posedge clk); #1;
        enq_valid = 0; deq_ready = 0;
        wait_idle(b);
        check("rt_count", count, 3);
        check("rt_head", deq_key, 3);
        for (int i = 0; i < 3; i++) begin
            do_deq(k, d, b);
            check("rt_drain_key", k, drain_min[i]);
        end
        check("rt_drain_empty", empty, 1);

        // Max mode with payloads riding along.
        sel = 1; limit = 0;
        for (int i = 0; i < 4; i++) do_enq(mv[i].in_k, mv[i].in_d, b);
        check("max_count", count, 4);
        for (int i = 0; i < 4; i++) begin
            do_deq(k, d, b);
            check("max_drain_key", k, mv[i].ex_k);
            check("max_drain_data", d, mv[i].ex_d);
        end
        check("max_empty", empty, 1);

        // Asynchronous reset in the middle of a sift-down.
        sel = 0; limit = 0;
        do_enq(5, 8'h50, b);
        do_enq(1, 8'h51, b);
        do_enq(8, 8'h52, b);
        @(negedge clk);
        deq_ready = 1;
        #1;
        check("ar_pre_deq_valid", deq_valid, 1);
        @(posedge clk); #1;
        deq_ready = 0;
        #1;
        check("ar_busy_before", busy, 1);
        rst_n = 0;
        #1;
        check("ar_count", count, 0);
        check("ar_deq_valid", deq_valid, 0);
        check("ar_busy", busy, 0);
        check("ar_empty", empty, 1);
        @(negedge clk);
        rst_n = 1;
        #1;
        check("ar_enq_ready", enq_ready, 1);
        do_enq(6, 8'h66, b);
        check("ar_head", deq_key, 6);
        check("ar_head_data", deq_data, 8'h66);
        check("ar_count_after", count, 1);

        sel = 0;
        do_reset();
        run_random(500);
        sel = 1;
        do_reset();
        run_random(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
